// File: rtl/vx_reduce_sched_pkg.sv
// rtl/vx_reduce_sched_pkg.sv - shared states, widths and sizing helpers for the reduce scheduler
package vx_reduce_sched_pkg;

   localparam int RS_STATE_W         = 2;
   localparam int RS_NUM_REQS_DEF    = 4;
   localparam int RS_DATAW_DEF       = 64;
   localparam int RS_MAX_PACKETS_DEF = 4;

   // Lock lifecycle: arbitrate, one bubble, forward the owner's packets, wait for commit.
   typedef enum logic [RS_STATE_W-1:0] {
      RS_IDLE   = 2'd0,
      RS_GRANT  = 2'd1,
      RS_STREAM = 2'd2,
      RS_DRAIN  = 2'd3
   } rs_state_e;

   // Requester index width; never narrower than one bit.
   function automatic int rs_idx_w(input int num_reqs);
      return (num_reqs <= 1) ? 1 : $clog2(num_reqs);
   endfunction

   // Packet counter width able to represent 0..max_packets.
   function automatic int rs_cnt_w(input int max_packets);
      return (max_packets <= 1) ? 1 : $clog2(max_packets + 1);
   endfunction

endpackage

// File: rtl/vx_reduce_sched_if.sv
// rtl/vx_reduce_sched_if.sv - requester, reduce-unit and commit handshakes of the reduce scheduler
interface vx_reduce_sched_if #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 64
);
   logic [NUM_REQS-1:0]            req_valid;
   logic [NUM_REQS-1:0][DATAW-1:0] req_data;
   logic [NUM_REQS-1:0]            req_sop;
   logic [NUM_REQS-1:0]            req_eop;
   logic [NUM_REQS-1:0]            req_ready;

   logic                           red_valid;
   logic                           red_sop;
   logic                           red_eop;
   logic [DATAW-1:0]               red_data;
   logic                           red_ready;

   logic                           cmt_fire;
   logic                           cmt_eop;

   // Scheduler side.
   modport slave (
      input  req_valid, req_data, req_sop, req_eop,
      output req_ready,
      output red_valid, red_sop, red_eop, red_data,
      input  red_ready,
      input  cmt_fire, cmt_eop
   );

   // Issue slots plus reduce unit side.
   modport master (
      output req_valid, req_data, req_sop, req_eop,
      input  req_ready,
      input  red_valid, red_sop, red_eop, red_data,
      output red_ready,
      output cmt_fire, cmt_eop
   );
endinterface

// File: rtl/vx_reduce_sched_rr_select.sv
// rtl/vx_reduce_sched_rr_select.sv - round-robin pick of the first eligible requester at or after a pointer
module vx_reduce_sched_rr_select
   import vx_reduce_sched_pkg::*;
#(
   parameter  int NUM_REQS = RS_NUM_REQS_DEF,
   localparam int IDXW     = rs_idx_w(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0] eligible,
   input  logic [IDXW-1:0]     ptr,
   output logic [IDXW-1:0]     idx,
   output logic                valid
);

   // Walk the ring starting at ptr (inclusive); the first eligible slot wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
         int              cand;
         logic [IDXW-1:0] cand_idx;
         cand = int'(ptr) + i;
         if (cand >= NUM_REQS) begin
            cand = cand - NUM_REQS;
         end
         cand_idx = IDXW'(cand);
         if (!valid && eligible[cand_idx]) begin
            valid = 1'b1;
            idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/vx_reduce_sched.sv
// rtl/vx_reduce_sched.sv - issue-slot arbiter holding a reduction lock in front of the reduce unit
module vx_reduce_sched
   import vx_reduce_sched_pkg::*;
#(
   parameter  int NUM_REQS    = RS_NUM_REQS_DEF,
   parameter  int DATAW       = RS_DATAW_DEF,
   parameter  int MAX_PACKETS = RS_MAX_PACKETS_DEF,
   localparam int IDXW        = rs_idx_w(NUM_REQS)
) (
   input  logic             clk,
   input  logic             reset,
   vx_reduce_sched_if.slave bus,
   output logic             busy,
   output logic [IDXW-1:0]  grant_idx,
   output logic             err_overflow
);

   localparam int              CNTW     = rs_cnt_w(MAX_PACKETS);
   localparam logic [CNTW-1:0] PKT_LAST = CNTW'(MAX_PACKETS - 1);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_REQS - 1);

   rs_state_e           state_q, state_d;
   logic [IDXW-1:0]     grant_q, grant_d;
   logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNTW-1:0]     pkt_cnt_q, pkt_cnt_d;
   logic                err_q, err_d;

   logic [NUM_REQS-1:0] eligible;
   logic [IDXW-1:0]     win_idx;
   logic                win_valid;

   logic                own_valid;
   logic                own_sop;
   logic                own_eop;
   logic [DATAW-1:0]    own_data;
   logic                red_hs;
   logic                commit_done;
   logic [NUM_REQS-1:0] req_ready_c;
   logic                red_valid_c;
   logic                busy_c;

   // Only a requester presenting the first packet of a reduction may take the lock.
   assign eligible = bus.req_valid & bus.req_sop;

   vx_reduce_sched_rr_select #(
      .NUM_REQS (NUM_REQS)
   ) u_rr_select (
      .eligible (eligible),
      .ptr      (rr_ptr_q),
      .idx      (win_idx),
      .valid    (win_valid)
   );

   // The reduce-unit port is a pure mux of the lock owner's inputs; nothing is buffered.
   assign own_valid   = bus.req_valid[grant_q];
   assign own_sop     = bus.req_sop[grant_q];
   assign own_eop     = bus.req_eop[grant_q];
   assign own_data    = bus.req_data[grant_q];
   assign red_hs      = (state_q == RS_STREAM) && own_valid && bus.red_ready;
   assign commit_done = bus.cmt_fire && bus.cmt_eop;

   // Next-state, lock bookkeeping and handshake outputs; reset forces the handshakes quiet.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      pkt_cnt_d   = pkt_cnt_q;
      err_d       = err_q;
      req_ready_c = '0;
      red_valid_c = 1'b0;
      busy_c      = (state_q != RS_IDLE) && !reset;

      unique case (state_q)
         RS_IDLE: begin
            if (win_valid) begin
               grant_d = win_idx;
               state_d = RS_GRANT;
            end
         end
         RS_GRANT: begin
            pkt_cnt_d = '0;
            state_d   = RS_STREAM;
         end
         RS_STREAM: begin
            if (!reset) begin
               red_valid_c          = own_valid;
               req_ready_c[grant_q] = bus.red_ready;
            end
            if (red_hs) begin
               if (own_eop) begin
                  pkt_cnt_d = '0;
                  state_d   = RS_DRAIN;
               end else if (pkt_cnt_q == PKT_LAST) begin
                  // A reduction that never ends must not hold the lock forever.
                  pkt_cnt_d = '0;
                  err_d     = 1'b1;
                  state_d   = RS_DRAIN;
               end else begin
                  pkt_cnt_d = pkt_cnt_q + CNTW'(1);
               end
            end
         end
         RS_DRAIN: begin
            if (commit_done) begin
               rr_ptr_d = (grant_q == IDX_LAST) ? '0 : grant_q + IDXW'(1);
               grant_d  = '0;
               state_d  = RS_IDLE;
            end
         end
         default: begin
            state_d = RS_IDLE;
         end
      endcase
   end

   // State register with synchronous reset that abandons any reduction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RS_IDLE;
         grant_q   <= '0;
         rr_ptr_q  <= '0;
         pkt_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_ptr_q  <= rr_ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_q     <= err_d;
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.red_valid = red_valid_c;
   assign bus.red_sop   = own_sop;
   assign bus.red_eop   = own_eop;
   assign bus.red_data  = own_data;
   assign busy          = busy_c;
   assign grant_idx     = grant_q;
   assign err_overflow  = err_q;

endmodule
